// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int AW_DEF    = 16;
  localparam int IW_DEF    = 16;
  localparam int INC_DEF   = 2;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [IW_DEF-1:0] inst;
    logic [AW_DEF-1:0] pc;
  } fetch_entry_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with a combinational head view, used to buffer fetched
// instructions; flush empties it in one cycle and overrides push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  T                             i_data,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output T                             o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [cnt_width(DEPTH)-1:0]  o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Storage has no reset; only pointers and count carry state that matters.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch front end: owns the PC, issues in-order imem requests under a credit
// limit, squashes responses across redirects and queues results for decode.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int             AW       = AW_DEF,
  parameter int             IW       = IW_DEF,
  parameter int             INC      = INC_DEF,
  parameter int             DEPTH    = DEPTH_DEF,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hlt,
  input  logic           redirect,
  input  logic [AW-1:0]  redirect_pc,
  output logic           imem_req,
  output logic [AW-1:0]  imem_addr,
  input  logic           imem_rvalid,
  input  logic [IW-1:0]  imem_rdata,
  output logic           dec_valid,
  input  logic           dec_ready,
  output logic [IW-1:0]  dec_inst,
  output logic [AW-1:0]  dec_pc,
  output logic [AW-1:0]  dec_pc_next
);

  localparam int CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } entry_t;

  logic           r_run;
  logic [AW-1:0]  r_pc;
  logic [AW-1:0]  r_resp_pc;
  logic [CW-1:0]  r_outstanding;
  logic [CW-1:0]  r_drop_cnt;

  logic [CW-1:0]  w_occ;
  logic           w_full;
  logic           w_empty;
  entry_t         w_head;
  entry_t         w_push_entry;
  logic [CW:0]    w_credit_used;
  logic           w_issue;
  logic           w_drop;
  logic           w_push;
  logic           w_pop;

  // Every queue slot is reserved at issue time, so a response always fits.
  assign w_credit_used = {1'b0, w_occ} + {1'b0, r_outstanding};
  assign w_issue       = r_run && !hlt && !redirect && (w_credit_used < (CW+1)'(DEPTH));
  assign w_drop        = redirect || (r_drop_cnt != '0);
  assign w_push        = imem_rvalid && !w_drop;
  assign w_pop         = !w_empty && dec_ready;
  assign w_push_entry  = '{inst: imem_rdata, pc: r_resp_pc};

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign dec_valid   = !w_empty;
  assign dec_inst    = w_head.inst;
  assign dec_pc      = w_head.pc;
  assign dec_pc_next = w_head.pc + AW'(INC);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (w_push_entry),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  // r_run holds off the first request until the cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_run <= 1'b1;
      if (redirect) begin
        // Whatever is still in flight after this cycle belongs to the old path.
        r_pc          <= redirect_pc;
        r_resp_pc     <= redirect_pc;
        r_outstanding <= r_outstanding - CW'(imem_rvalid);
        r_drop_cnt    <= r_outstanding - CW'(imem_rvalid);
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + AW'(INC);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + AW'(INC);
        end
        if (imem_rvalid && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        r_outstanding <= r_outstanding + CW'(w_issue) - CW'(imem_rvalid);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      a_credit: assert (w_credit_used <= (CW+1)'(DEPTH));
      a_drop:   assert (r_drop_cnt <= r_outstanding);
      a_rvalid: assert (!(imem_rvalid && (r_outstanding == '0)));
      a_room:   assert (!(w_push && w_full && !w_pop));
    end
  end

endmodule
